// File: rtl/exc_commit_ctrl_pkg.sv
// Shared definitions for the exception/interrupt commit controller:
// ExcCode values, FSM encodings, event kinds and the default handler vector.
package exc_commit_ctrl_pkg;

  localparam logic [31:0] DEFAULT_HANDLER_PC = 32'hbfc00380;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  typedef enum logic [1:0] {
    EXC_S_IDLE  = 2'd0,
    EXC_S_DRAIN = 2'd1,
    EXC_S_REDIR = 2'd2
  } exc_state_e;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_EXC  = 2'd1,
    EV_ERET = 2'd2
  } exc_ev_e;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_commit_ctrl_prio.sv
// exc_prio_sel: combinational oldest-event selector across MEM, EX, ID and IF.
// Produces event kind, ExcCode, restart PC, BD bit and BadVAddr.
module exc_prio_sel
  import exc_commit_ctrl_pkg::*;
(
  input  logic        if_valid,
  input  logic        if_adef,
  input  logic [31:0] if_pc,
  input  logic        id_valid,
  input  logic        id_ri,
  input  logic        id_sys,
  input  logic        id_bp,
  input  logic        id_eret,
  input  logic        id_bd,
  input  logic [31:0] id_pc,
  input  logic        ex_valid,
  input  logic        ex_ov,
  input  logic        ex_ades,
  input  logic        ex_bd,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_addr,
  input  logic        mem_valid,
  input  logic        mem_adel,
  input  logic        mem_bd,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_addr,
  input  logic        int_req,
  output exc_ev_e     sel_type,
  output logic [4:0]  sel_code,
  output logic [31:0] sel_epc,
  output logic        sel_bd,
  output logic        sel_badv_we,
  output logic [31:0] sel_badv
);

  always_comb begin
    sel_type    = EV_NONE;
    sel_code    = 5'd0;
    sel_epc     = 32'd0;
    sel_bd      = 1'b0;
    sel_badv_we = 1'b0;
    sel_badv    = 32'd0;
    if (mem_valid && mem_adel) begin
      sel_type    = EV_EXC;
      sel_code    = EXC_ADEL;
      sel_epc     = epc_of(mem_pc, mem_bd);
      sel_bd      = mem_bd;
      sel_badv_we = 1'b1;
      sel_badv    = mem_addr;
    end else if (ex_valid && (ex_ades || ex_ov)) begin
      sel_type = EV_EXC;
      sel_code = ex_ades ? EXC_ADES : EXC_OV;
      sel_epc  = epc_of(ex_pc, ex_bd);
      sel_bd   = ex_bd;
      if (ex_ades) begin
        sel_badv_we = 1'b1;
        sel_badv    = ex_addr;
      end
    end else if (id_valid && (int_req || id_ri || id_sys || id_bp)) begin
      // Interrupts are attached to the ID instruction, ahead of its own faults.
      sel_type = EV_EXC;
      sel_epc  = epc_of(id_pc, id_bd);
      sel_bd   = id_bd;
      if (int_req)     sel_code = EXC_INT;
      else if (id_ri)  sel_code = EXC_RI;
      else if (id_sys) sel_code = EXC_SYS;
      else             sel_code = EXC_BP;
    end else if (id_valid && id_eret) begin
      sel_type = EV_ERET;
    end else if (if_valid && if_adef) begin
      sel_type    = EV_EXC;
      sel_code    = EXC_ADEL;
      sel_epc     = if_pc;
      sel_badv_we = 1'b1;
      sel_badv    = if_pc;
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt commit controller: CP0 strobes, flush, fetch drain and IF redirect.
// Optional EXC_HWINT_EN adds a registered 6-bit hw_int input feeding the interrupt term.
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = DEFAULT_HANDLER_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic        if_adef,
  input  logic [31:0] if_pc,
  input  logic        id_valid,
  input  logic        id_ri,
  input  logic        id_sys,
  input  logic        id_bp,
  input  logic        id_eret,
  input  logic        id_bd,
  input  logic [31:0] id_pc,
  input  logic        ex_valid,
  input  logic        ex_ov,
  input  logic        ex_ades,
  input  logic        ex_bd,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_addr,
  input  logic        mem_valid,
  input  logic        mem_adel,
  input  logic        mem_bd,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_addr,
  input  logic        int_pending,
  input  logic        cp0_exl,
  input  logic [31:0] cp0_epc_in,   // current EPC (output cp0_epc is the write value)
`ifdef EXC_HWINT_EN
  input  logic [5:0]  hw_int,
`endif
  input  logic        fetch_busy,
  input  logic        inst_data_ok,
  input  logic        redirect_ack,
  output logic        flush,
  output logic        stall_if,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        cp0_exc_we,
  output logic [4:0]  cp0_exc_code,
  output logic        cp0_epc_we,
  output logic [31:0] cp0_epc,
  output logic        cp0_bd,
  output logic        cp0_badv_we,
  output logic [31:0] cp0_badv,
  output logic        cp0_eret_we,
  output logic [1:0]  dbg_state
);

  exc_state_e  state_q, state_d;
  logic [31:0] target_q, target_d;
  logic        int_req;

  exc_ev_e     sel_type;
  logic [4:0]  sel_code;
  logic [31:0] sel_epc;
  logic        sel_bd;
  logic        sel_badv_we;
  logic [31:0] sel_badv;

`ifdef EXC_HWINT_EN
  logic [5:0] hw_int_q, hw_int_d;
  assign hw_int_d = hw_int;
  always_ff @(posedge clk) begin
    if (rst) hw_int_q <= 6'd0;
    else     hw_int_q <= hw_int_d;
  end
  assign int_req = int_pending | ((|hw_int_q) & ~cp0_exl);
`else
  assign int_req = int_pending;
`endif

  exc_prio_sel u_prio (
    .if_valid    (if_valid),
    .if_adef     (if_adef),
    .if_pc       (if_pc),
    .id_valid    (id_valid),
    .id_ri       (id_ri),
    .id_sys      (id_sys),
    .id_bp       (id_bp),
    .id_eret     (id_eret),
    .id_bd       (id_bd),
    .id_pc       (id_pc),
    .ex_valid    (ex_valid),
    .ex_ov       (ex_ov),
    .ex_ades     (ex_ades),
    .ex_bd       (ex_bd),
    .ex_pc       (ex_pc),
    .ex_addr     (ex_addr),
    .mem_valid   (mem_valid),
    .mem_adel    (mem_adel),
    .mem_bd      (mem_bd),
    .mem_pc      (mem_pc),
    .mem_addr    (mem_addr),
    .int_req     (int_req),
    .sel_type    (sel_type),
    .sel_code    (sel_code),
    .sel_epc     (sel_epc),
    .sel_bd      (sel_bd),
    .sel_badv_we (sel_badv_we),
    .sel_badv    (sel_badv)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EXC_S_IDLE;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    flush          = 1'b0;
    stall_if       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    cp0_exc_we     = 1'b0;
    cp0_exc_code   = 5'd0;
    cp0_epc_we     = 1'b0;
    cp0_epc        = 32'd0;
    cp0_bd         = 1'b0;
    cp0_badv_we    = 1'b0;
    cp0_badv       = 32'd0;
    cp0_eret_we    = 1'b0;
    // Outputs stay quiet while rst is held so the reset cycle is clean.
    if (!rst) begin
      unique case (state_q)
        EXC_S_IDLE: begin
          if (sel_type != EV_NONE) begin
            flush    = 1'b1;
            state_d  = (fetch_busy && !inst_data_ok) ? EXC_S_DRAIN : EXC_S_REDIR;
            if (sel_type == EV_ERET) begin
              cp0_eret_we = 1'b1;
              target_d    = cp0_epc_in;
            end else begin
              cp0_exc_we   = 1'b1;
              cp0_exc_code = sel_code;
              cp0_epc_we   = ~cp0_exl;
              cp0_epc      = sel_epc;
              cp0_bd       = sel_bd;
              cp0_badv_we  = sel_badv_we;
              cp0_badv     = sel_badv;
              target_d     = HANDLER_PC;
            end
          end
        end
        EXC_S_DRAIN: begin
          stall_if = 1'b1;
          if (inst_data_ok) state_d = EXC_S_REDIR;
        end
        EXC_S_REDIR: begin
          redirect_valid = 1'b1;
          redirect_pc    = target_q;
          if (redirect_ack) state_d = EXC_S_IDLE;
        end
        default: state_d = EXC_S_IDLE;
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl: inputs driven on the falling edge,
// outputs checked 1ns later; one task per scenario.
module tb_exc_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_adef;
  logic [31:0] if_pc;
  logic        id_valid, id_ri, id_sys, id_bp, id_eret, id_bd;
  logic [31:0] id_pc;
  logic        ex_valid, ex_ov, ex_ades, ex_bd;
  logic [31:0] ex_pc, ex_addr;
  logic        mem_valid, mem_adel, mem_bd;
  logic [31:0] mem_pc, mem_addr;
  logic        int_pending, cp0_exl;
  logic [31:0] cp0_epc_in;
`ifdef EXC_HWINT_EN
  logic [5:0]  hw_int;
`endif
  logic        fetch_busy, inst_data_ok, redirect_ack;
  logic        flush, stall_if, redirect_valid;
  logic [31:0] redirect_pc;
  logic        cp0_exc_we;
  logic [4:0]  cp0_exc_code;
  logic        cp0_epc_we;
  logic [31:0] cp0_epc;
  logic        cp0_bd, cp0_badv_we;
  logic [31:0] cp0_badv;
  logic        cp0_eret_we;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exc_commit_ctrl dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_adef(if_adef), .if_pc(if_pc),
    .id_valid(id_valid), .id_ri(id_ri), .id_sys(id_sys), .id_bp(id_bp),
    .id_eret(id_eret), .id_bd(id_bd), .id_pc(id_pc),
    .ex_valid(ex_valid), .ex_ov(ex_ov), .ex_ades(ex_ades), .ex_bd(ex_bd),
    .ex_pc(ex_pc), .ex_addr(ex_addr),
    .mem_valid(mem_valid), .mem_adel(mem_adel), .mem_bd(mem_bd),
    .mem_pc(mem_pc), .mem_addr(mem_addr),
    .int_pending(int_pending), .cp0_exl(cp0_exl), .cp0_epc_in(cp0_epc_in),
`ifdef EXC_HWINT_EN
    .hw_int(hw_int),
`endif
    .fetch_busy(fetch_busy), .inst_data_ok(inst_data_ok), .redirect_ack(redirect_ack),
    .flush(flush), .stall_if(stall_if), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .cp0_exc_we(cp0_exc_we), .cp0_exc_code(cp0_exc_code),
    .cp0_epc_we(cp0_epc_we), .cp0_epc(cp0_epc), .cp0_bd(cp0_bd),
    .cp0_badv_we(cp0_badv_we), .cp0_badv(cp0_badv), .cp0_eret_we(cp0_eret_we),
    .dbg_state(dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_events();
    if_valid = 0; if_adef = 0; if_pc = 0;
    id_valid = 0; id_ri = 0; id_sys = 0; id_bp = 0; id_eret = 0; id_bd = 0; id_pc = 0;
    ex_valid = 0; ex_ov = 0; ex_ades = 0; ex_bd = 0; ex_pc = 0; ex_addr = 0;
    mem_valid = 0; mem_adel = 0; mem_bd = 0; mem_pc = 0; mem_addr = 0;
    int_pending = 0; cp0_exl = 0; cp0_epc_in = 0;
`ifdef EXC_HWINT_EN
    hw_int = 0;
`endif
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic ack_redirect();
    redirect_ack = 1;
    next_cycle();
    redirect_ack = 0;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    clear_events();
    fetch_busy = 0; inst_data_ok = 0; redirect_ack = 0;
    rst = 1;
    next_cycle(); next_cycle();
    rst = 0;
    #1;
    outs = {flush, stall_if, redirect_valid, cp0_exc_we, cp0_epc_we, cp0_bd,
            cp0_badv_we, cp0_eret_we, cp0_exc_code, dbg_state};
    checks++;
    if (outs !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", outs); end
    checks++;
    if ((redirect_pc | cp0_epc | cp0_badv) !== 32'd0) begin
      errors++; $display("FAIL reset_data: got pc=%h epc=%h badv=%h expected 0", redirect_pc, cp0_epc, cp0_badv);
    end
    next_cycle();
  endtask

  task automatic test_ex_ov_bd();
    ex_valid = 1; ex_ov = 1; ex_pc = 32'hbfc00100; ex_bd = 1;
    #1;
    checks++;
    if ({flush, cp0_exc_we, cp0_epc_we, cp0_bd, cp0_badv_we, cp0_eret_we} !== 6'b111100) begin
      errors++; $display("FAIL ov_strobes: got %b expected 111100",
        {flush, cp0_exc_we, cp0_epc_we, cp0_bd, cp0_badv_we, cp0_eret_we});
    end
    checks++;
    if (cp0_exc_code !== 5'h0c) begin errors++; $display("FAIL ov_code: got %h expected 0c", cp0_exc_code); end
    checks++;
    if (cp0_epc !== 32'hbfc000fc) begin errors++; $display("FAIL ov_epc: got %h expected bfc000fc", cp0_epc); end
    next_cycle();
    clear_events();
    #1;
    checks++;
    if ({redirect_valid, flush, cp0_exc_we} !== 3'b100) begin
      errors++; $display("FAIL ov_redir_pulse: got %b expected 100", {redirect_valid, flush, cp0_exc_we});
    end
    checks++;
    if (redirect_pc !== 32'hbfc00380) begin errors++; $display("FAIL ov_redir_pc: got %h expected bfc00380", redirect_pc); end
    // a new event while redirecting must be ignored
    ex_valid = 1; ex_ades = 1; ex_addr = 32'h10;
    #1;
    checks++;
    if ({flush, cp0_exc_we, cp0_badv_we} !== 3'b000) begin
      errors++; $display("FAIL ignore_in_redir: got %b expected 000", {flush, cp0_exc_we, cp0_badv_we});
    end
    clear_events();
    next_cycle();
    checks++;
    if (redirect_pc !== 32'hbfc00380) begin errors++; $display("FAIL redir_hold: got %h expected bfc00380", redirect_pc); end
    ack_redirect();
    #1;
    checks++;
    if ({redirect_valid, dbg_state} !== 3'b000) begin
      errors++; $display("FAIL ov_back_idle: got %b expected 000", {redirect_valid, dbg_state});
    end
  endtask

  task automatic test_mem_adel_priority();
    mem_valid = 1; mem_adel = 1; mem_addr = 32'h3; mem_pc = 32'hbfc00010;
    id_valid = 1; id_sys = 1; id_pc = 32'hbfc00018;
    #1;
    checks++;
    if (cp0_exc_code !== 5'h04) begin errors++; $display("FAIL adel_code: got %h expected 04", cp0_exc_code); end
    checks++;
    if ({cp0_badv_we, cp0_badv} !== {1'b1, 32'h3}) begin
      errors++; $display("FAIL adel_badv: got we=%b v=%h expected we=1 v=3", cp0_badv_we, cp0_badv);
    end
    checks++;
    if ({cp0_epc, cp0_bd} !== {32'hbfc00010, 1'b0}) begin
      errors++; $display("FAIL adel_epc: got %h bd=%b expected bfc00010 bd=0", cp0_epc, cp0_bd);
    end
    next_cycle();
    clear_events();
    ack_redirect();
  endtask

  task automatic test_if_adef_drain();
    if_valid = 1; if_adef = 1; if_pc = 32'hbfc00002; fetch_busy = 1;
    #1;
    checks++;
    if ({cp0_exc_code, cp0_badv, cp0_epc, cp0_bd} !== {5'h04, 32'hbfc00002, 32'hbfc00002, 1'b0}) begin
      errors++; $display("FAIL adef_detect: got code=%h badv=%h epc=%h bd=%b expected 04 bfc00002 bfc00002 0",
        cp0_exc_code, cp0_badv, cp0_epc, cp0_bd);
    end
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      clear_events();
      if (i == 3) inst_data_ok = 1;
      #1;
      checks++;
      if ({stall_if, redirect_valid, flush} !== 3'b100) begin
        errors++; $display("FAIL drain_cycle%0d: got %b expected 100", i, {stall_if, redirect_valid, flush});
      end
    end
    next_cycle();
    inst_data_ok = 0; fetch_busy = 0;
    #1;
    checks++;
    if ({stall_if, redirect_valid, redirect_pc} !== {2'b01, 32'hbfc00380}) begin
      errors++; $display("FAIL drain_redir: got stall=%b rv=%b pc=%h expected 0 1 bfc00380",
        stall_if, redirect_valid, redirect_pc);
    end
    ack_redirect();
  endtask

  task automatic test_eret_same_cycle_ack();
    id_valid = 1; id_eret = 1; cp0_epc_in = 32'hbfc00200;
    #1;
    checks++;
    if ({cp0_eret_we, cp0_exc_we, cp0_epc_we, flush} !== 4'b1001) begin
      errors++; $display("FAIL eret_strobes: got %b expected 1001", {cp0_eret_we, cp0_exc_we, cp0_epc_we, flush});
    end
    next_cycle();
    clear_events();
    redirect_ack = 1;
    #1;
    checks++;
    if ({redirect_valid, redirect_pc, cp0_eret_we} !== {1'b1, 32'hbfc00200, 1'b0}) begin
      errors++; $display("FAIL eret_redir: got rv=%b pc=%h eret=%b expected 1 bfc00200 0",
        redirect_valid, redirect_pc, cp0_eret_we);
    end
    next_cycle();
    redirect_ack = 0;
    checks++;
    if ({redirect_valid, dbg_state} !== 3'b000) begin
      errors++; $display("FAIL eret_idle: got %b expected 000", {redirect_valid, dbg_state});
    end
  endtask

  task automatic test_interrupt_and_exl();
    int_pending = 1; id_valid = 1; id_ri = 1; id_pc = 32'hbfc00040;
    #1;
    checks++;
    if ({cp0_exc_code, cp0_epc, cp0_epc_we} !== {5'h00, 32'hbfc00040, 1'b1}) begin
      errors++; $display("FAIL int_detect: got code=%h epc=%h we=%b expected 00 bfc00040 1",
        cp0_exc_code, cp0_epc, cp0_epc_we);
    end
    next_cycle();
    clear_events();
    ack_redirect();
    cp0_exl = 1; id_valid = 1; id_sys = 1; id_bd = 1; id_pc = 32'hbfc00060;
    #1;
    checks++;
    if ({cp0_exc_we, cp0_epc_we, cp0_exc_code} !== {2'b10, 5'h08}) begin
      errors++; $display("FAIL exl_sys: got we=%b epc_we=%b code=%h expected 1 0 08",
        cp0_exc_we, cp0_epc_we, cp0_exc_code);
    end
    next_cycle();
    clear_events();
    #1;
    checks++;
    if (redirect_pc !== 32'hbfc00380) begin errors++; $display("FAIL exl_redir_pc: got %h expected bfc00380", redirect_pc); end
    ack_redirect();
    id_valid = 1; id_bp = 1; id_pc = 32'hbfc00070;
    #1;
    checks++;
    if (cp0_exc_code !== 5'h09) begin errors++; $display("FAIL bp_code: got %h expected 09", cp0_exc_code); end
    next_cycle();
    clear_events();
    ack_redirect();
  endtask

  task automatic test_reset_mid_redirect();
    ex_valid = 1; ex_ov = 1; ex_pc = 32'hbfc00120;
    next_cycle();
    clear_events();
    #1;
    checks++;
    if (redirect_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_redir: got %b expected 1", redirect_valid); end
    rst = 1;
    next_cycle();
    rst = 0;
    #1;
    checks++;
    if ({flush, stall_if, redirect_valid, cp0_exc_we, cp0_eret_we, dbg_state, redirect_pc} !== 38'd0) begin
      errors++; $display("FAIL rst_mid_redir: got rv=%b pc=%h state=%0d expected all 0",
        redirect_valid, redirect_pc, dbg_state);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_ex_ov_bd();
    test_mem_adel_priority();
    test_if_adef_drain();
    test_eret_same_cycle_ack();
    test_interrupt_and_exl();
    test_reset_mid_redirect();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
